// File: rtl/ro_freq_meter.sv
// Multi-channel ring-oscillator frequency meter: counts rising edges per channel over a 2^GATE_LOG2 gate.
// Latency: SYNC_STAGES+1 settle + 2^GATE_LOG2 gate + 1 report cycles per channel; done is high in the report cycle.
// No backpressure: done is a one-cycle pulse. Optional macro RO_FREQ_METER_PEAK_EN adds a running peak register.
module ro_freq_meter #(
    parameter int NCH         = 4,
    parameter int CW          = 16,
    parameter int GATE_LOG2   = 10,
    parameter int SYNC_STAGES = 2,
    localparam int IW         = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           ena,
    input  logic [NCH-1:0] osc_in,
    input  logic [NCH-1:0] chan_mask,
    input  logic           start,
    input  logic           continuous,
    output logic           busy,
    output logic           done,
    output logic [IW-1:0]  result_chan,
    output logic [CW-1:0]  result,
    output logic           overflow
`ifdef RO_FREQ_METER_PEAK_EN
    ,
    input  logic           peak_clr,
    output logic [CW-1:0]  peak
`endif
);

    localparam int SETTLE_N = SYNC_STAGES + 1;
    localparam int GATE_N   = 1 << GATE_LOG2;
    localparam int TMAX     = (SETTLE_N > GATE_N) ? SETTLE_N : GATE_N;
    localparam int TW       = $clog2(TMAX + 1);
    localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_N - 1);
    localparam logic [TW-1:0] GATE_LAST   = TW'(GATE_N - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, GATE, REPORT} state_e;

    state_e           state_q, state_d;
    logic [NCH-1:0]   sync_q [SYNC_STAGES];
    logic [NCH-1:0]   prev_q;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [IW-1:0]    sel_q, sel_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    result_q;
    logic [IW-1:0]    result_chan_q;
    logic             overflow_q;
    logic             load;
    logic [NCH-1:0]   rise;
    logic [IW-1:0]    low_in, low_q, nxt_idx;
    logic             nxt_vld;

    assign rise        = sync_q[SYNC_STAGES-1] & ~prev_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == REPORT);
    assign result      = result_q;
    assign result_chan = result_chan_q;
    assign overflow    = overflow_q;

    // Free-running input synchronisers plus one delayed copy for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            prev_q <= '0;
        end else begin
            sync_q[0] <= osc_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // Channel pickers: lowest bit of the new mask, lowest captured bit, and next captured bit above sel_q.
    always_comb begin
        low_in  = '0;
        low_q   = '0;
        nxt_idx = '0;
        nxt_vld = 1'b0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (chan_mask[i]) low_in = IW'(i);
            if (mask_q[i])    low_q  = IW'(i);
            if (mask_q[i] && (i > int'(sel_q))) begin
                nxt_idx = IW'(i);
                nxt_vld = 1'b1;
            end
        end
    end

    // Next-state logic. Results are loaded on the final gate cycle so they are already valid while done is high.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        sel_d   = sel_q;
        timer_d = timer_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start && ena && (chan_mask != '0)) begin
                    mask_d  = chan_mask;
                    sel_d   = low_in;
                    timer_d = SETTLE_LAST;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                cnt_d = '0;
                ovf_d = 1'b0;
                if (timer_q == '0) begin
                    timer_d = GATE_LAST;
                    state_d = GATE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            GATE: begin
                if (rise[sel_q]) begin
                    if (cnt_q == {CW{1'b1}}) ovf_d = 1'b1;
                    else                     cnt_d = cnt_q + 1'b1;
                end
                if (timer_q == '0) begin
                    load    = 1'b1;
                    state_d = REPORT;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            REPORT: begin
                timer_d = SETTLE_LAST;
                if (nxt_vld) begin
                    sel_d   = nxt_idx;
                    state_d = SETTLE;
                end else if (continuous) begin
                    sel_d   = low_q;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!ena) begin
            state_d = IDLE;
            load    = 1'b0;
        end
    end

    // FSM, measurement and result registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mask_q        <= '0;
            sel_q         <= '0;
            timer_q       <= '0;
            cnt_q         <= '0;
            ovf_q         <= 1'b0;
            result_q      <= '0;
            result_chan_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            sel_q   <= sel_d;
            timer_q <= timer_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (load) begin
                result_q      <= cnt_d;
                result_chan_q <= sel_q;
                overflow_q    <= ovf_d;
            end
        end
    end

`ifdef RO_FREQ_METER_PEAK_EN
    logic [CW-1:0] peak_q;
    assign peak = peak_q;

    // Running maximum of reported results; a clear coinciding with done restarts from that result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_q <= '0;
        end else if (peak_clr) begin
            peak_q <= done ? result_q : '0;
        end else if (done && (result_q > peak_q)) begin
            peak_q <= result_q;
        end
    end
`endif

endmodule

// File: tb/tb_ro_freq_meter.sv
module tb_ro_freq_meter;
    localparam int NCH = 4;
    localparam int GL  = 6;
    localparam int SS  = 3;
    localparam int CWA = 16;
    localparam int CWB = 4;
    localparam int SPACING = (SS + 1) + (1 << GL) + 1;

    logic clk = 1'b0;
    logic reset_n, ena, start, continuous;
    logic [3:0] chan_mask;
    logic [3:0] osc_a = '0;
    logic [3:0] osc_b = '0;
    logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
    logic [1:0] chan_a, chan_b;
    logic [CWA-1:0] res_a;
    logic [CWB-1:0] res_b;
`ifdef RO_FREQ_METER_PEAK_EN
    logic peak_clr;
    logic [CWA-1:0] peak_a;
    logic [CWB-1:0] peak_b;
`endif

    ro_freq_meter #(.NCH(NCH), .CW(CWA), .GATE_LOG2(GL), .SYNC_STAGES(SS)) u_dut (
        .clk(clk), .reset_n(reset_n), .ena(ena), .osc_in(osc_a), .chan_mask(chan_mask),
        .start(start), .continuous(continuous), .busy(busy_a), .done(done_a),
        .result_chan(chan_a), .result(res_a), .overflow(ovf_a)
`ifdef RO_FREQ_METER_PEAK_EN
        , .peak_clr(peak_clr), .peak(peak_a)
`endif
    );

    ro_freq_meter #(.NCH(NCH), .CW(CWB), .GATE_LOG2(GL), .SYNC_STAGES(SS)) u_sat (
        .clk(clk), .reset_n(reset_n), .ena(ena), .osc_in(osc_b), .chan_mask(chan_mask),
        .start(start), .continuous(continuous), .busy(busy_b), .done(done_b),
        .result_chan(chan_b), .result(res_b), .overflow(ovf_b)
`ifdef RO_FREQ_METER_PEAK_EN
        , .peak_clr(peak_clr), .peak(peak_b)
`endif
    );

    always #5 clk = ~clk;

    // Oscillator sources: square waves with a period of per[ch] clk cycles (0 = stuck low).
    int per_a[4] = '{0, 0, 0, 0};
    int off_a[4] = '{0, 0, 0, 0};
    int per_b[4] = '{0, 0, 0, 0};
    int cyc = 0;
    always @(negedge clk) begin
        cyc = cyc + 1;
        for (int ch = 0; ch < 4; ch++) begin
            osc_a[ch] = (per_a[ch] == 0) ? 1'b0 : (((cyc + off_a[ch]) % per_a[ch]) >= per_a[ch] / 2);
            osc_b[ch] = (per_b[ch] == 0) ? 1'b0 : ((cyc % per_b[ch]) >= per_b[ch] / 2);
        end
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: a periodic source with period p dividing the gate shows gate/p rising edges.
    function automatic int model_edges(input int p);
        return (1 << GL) / p;
    endfunction
    function automatic int model_count(input int p, input int cw);
        int e = model_edges(p);
        int mx = (1 << cw) - 1;
        return (e > mx) ? mx : e;
    endfunction

    task automatic wait_done(input bit use_b, input int limit, output bit seen, output int waited);
        seen = 1'b0;
        waited = limit;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (use_b ? done_b : done_a) begin
                seen = 1'b1;
                waited = i;
                break;
            end
        end
    endtask

    task automatic do_start(input logic [3:0] m);
        @(negedge clk);
        chan_mask = m;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_scan(input logic [3:0] m, input int n, input int ch[4], input int cn[4], input string tag);
        bit seen;
        int w;
        do_start(m);
        for (int k = 0; k < n; k++) begin
            wait_done(1'b0, 200, seen, w);
            check({tag, "_done_seen"}, seen, 1);
            if (k > 0) check({tag, "_spacing"}, w, SPACING);
            check({tag, "_chan"}, chan_a, ch[k]);
            check({tag, "_result"}, res_a, cn[k]);
            check({tag, "_overflow"}, ovf_a, 0);
            check({tag, "_busy_at_done"}, busy_a, 1);
        end
        @(negedge clk);
        check({tag, "_busy_after"}, busy_a, 0);
    endtask

    typedef struct {
        logic [3:0] mask;
        int per[4];
        int n;
        int chan[4];
        int cnt[4];
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen, busy_seen;
        int w;
        int ech[4], ecn[4];
        int n;
        logic [3:0] m;

        vecs[0] = '{4'b0001, '{8, 0, 0, 0},  1, '{0, 0, 0, 0}, '{8, 0, 0, 0}};
        vecs[1] = '{4'b1010, '{0, 4, 0, 16}, 2, '{1, 3, 0, 0}, '{16, 4, 0, 0}};
        vecs[2] = '{4'b1111, '{2, 4, 8, 64}, 4, '{0, 1, 2, 3}, '{32, 16, 8, 1}};
        vecs[3] = '{4'b0100, '{0, 0, 32, 0}, 1, '{2, 0, 0, 0}, '{2, 0, 0, 0}};

        reset_n = 1'b0; ena = 1'b1; start = 1'b0; continuous = 1'b0; chan_mask = '0;
`ifdef RO_FREQ_METER_PEAK_EN
        peak_clr = 1'b0;
`endif
        repeat (3) @(negedge clk);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_result", res_a, 0);
        check("rst_chan", chan_a, 0);
        check("rst_ovf", ovf_a, 0);
        check("rst_result_b", res_b, 0);
`ifdef RO_FREQ_METER_PEAK_EN
        check("rst_peak", peak_a, 0);
`endif
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single passes.
        for (int v = 0; v < 4; v++) begin
            per_a = vecs[v].per;
            check_scan(vecs[v].mask, vecs[v].n, vecs[v].chan, vecs[v].cnt, $sformatf("vec%0d", v));
        end

        // Randomized passes checked against the edge-count model.
        for (int it = 0; it < 6; it++) begin
            m = 4'($urandom_range(1, 15));
            for (int ch = 0; ch < 4; ch++) begin
                per_a[ch] = 2 << $urandom_range(0, 5);
                off_a[ch] = $urandom_range(0, 63);
            end
            n = 0;
            ech = '{0, 0, 0, 0};
            ecn = '{0, 0, 0, 0};
            for (int ch = 0; ch < 4; ch++) begin
                if (m[ch]) begin
                    ech[n] = ch;
                    ecn[n] = model_count(per_a[ch], CWA);
                    n++;
                end
            end
            check_scan(m, n, ech, ecn, $sformatf("rnd%0d", it));
        end

        // Saturation on the narrow-count instance: 32, 16 (exact overflow boundary) and 8 edges.
        per_a = '{0, 0, 0, 0};
        for (int s = 0; s < 3; s++) begin
            per_b[0] = 2 << s;
            do_start(4'b0001);
            wait_done(1'b1, 200, seen, w);
            check($sformatf("sat%0d_seen", s), seen, 1);
            check($sformatf("sat%0d_result", s), res_b, model_count(per_b[0], CWB));
            check($sformatf("sat%0d_ovf", s), ovf_b, (model_edges(per_b[0]) > 15) ? 1 : 0);
            check($sformatf("sat%0d_chan", s), chan_b, 0);
            @(negedge clk);
            check($sformatf("sat%0d_busy_after", s), busy_b, 0);
        end

        // Continuous scan alternating channels 0 and 2, then stop after the next channel-2 result.
        per_a = '{8, 0, 4, 0};
        continuous = 1'b1;
        do_start(4'b0101);
        for (int k = 0; k < 5; k++) begin
            wait_done(1'b0, 200, seen, w);
            check($sformatf("cont%0d_seen", k), seen, 1);
            check($sformatf("cont%0d_chan", k), chan_a, (k % 2 == 0) ? 0 : 2);
            check($sformatf("cont%0d_result", k), res_a, (k % 2 == 0) ? 8 : 16);
        end
        continuous = 1'b0;
        wait_done(1'b0, 200, seen, w);
        check("cont_last_seen", seen, 1);
        check("cont_last_chan", chan_a, 2);
        check("cont_last_spacing", w, SPACING);
        @(negedge clk);
        check("cont_busy_after", busy_a, 0);
        wait_done(1'b0, 150, seen, w);
        check("cont_no_more_done", seen, 0);

        // ena dropped mid-gate: idle next cycle, previous result held, no done.
        do_start(4'b0001);
        repeat (30) @(negedge clk);
        ena = 1'b0;
        @(negedge clk);
        check("ena_busy", busy_a, 0);
        check("ena_done", done_a, 0);
        check("ena_result_held", res_a, 16);
        check("ena_chan_held", chan_a, 2);
        ena = 1'b1;
        wait_done(1'b0, 150, seen, w);
        check("ena_no_done", seen, 0);

        // Reset mid-measurement clears everything at once.
        do_start(4'b0001);
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("mrst_busy", busy_a, 0);
        check("mrst_done", done_a, 0);
        check("mrst_result", res_a, 0);
        check("mrst_chan", chan_a, 0);
        check("mrst_ovf", ovf_a, 0);
        check("mrst_result_b", res_b, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // start with an empty mask is ignored.
        do_start(4'b0000);
        busy_seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (busy_a) busy_seen = 1'b1;
        end
        check("mask0_busy", busy_seen, 0);

`ifdef RO_FREQ_METER_PEAK_EN
        per_a = '{8, 16, 0, 0};
        do_start(4'b0011);
        wait_done(1'b0, 200, seen, w);
        @(negedge clk);
        check("peak_after_8", peak_a, 8);
        wait_done(1'b0, 200, seen, w);
        check("peak_res4", res_a, 4);
        @(negedge clk);
        check("peak_after_4", peak_a, 8);
        do_start(4'b0010);
        wait_done(1'b0, 200, seen, w);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("peak_clr_with_done", peak_a, 4);
        peak_clr = 1'b1;
        @(negedge clk);
        peak_clr = 1'b0;
        check("peak_clr_alone", peak_a, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ro_freq_meter.md
Name: ro_freq_meter

Overview:
Parametrised multi-channel frequency meter for the divided ring-oscillator outputs (oscdiv-style taps) of the VGA/ring-oscillator designs.
- Synchronises NCH asynchronous, slow oscillator inputs into the clk domain.
- Counts rising edges of one channel at a time over a fixed gate window of clk cycles.
- Scans the enabled channels round-robin and presents each latched count with its channel index.
- Sits beside the ring/worker logic; its results feed a display or debug path.

Parameters:
NCH, 4, number of oscillator input channels (1..16)
CW, 16, count/result width in bits
GATE_LOG2, 10, gate window length = 2^GATE_LOG2 clk cycles
SYNC_STAGES, 2, flops in each input synchroniser (>=2)

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
ena  input  1  block enable; low forces IDLE
osc_in  input  NCH  asynchronous oscillator inputs, must be slower than clk/2
chan_mask  input  NCH  channel enable mask, sampled at start
start  input  1  one-cycle request to begin a scan
continuous  input  1  1 = rescan forever; 0 = one pass over the mask
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when result/result_chan are updated
result_chan  output  max(1,$clog2(NCH))  channel index of the latched result
result  output  CW  latched edge count
overflow  output  1  latched: count saturated during that measurement

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; counters, synchroniser flops and the captured mask all 0.
- Every osc_in bit passes through a SYNC_STAGES-flop synchroniser, running continuously. Rising edge = last stage 1 and prior-cycle copy 0.
- FSM states: IDLE, SETTLE, GATE, REPORT.
- IDLE:
  - start=1, ena=1 and chan_mask!=0: capture the mask, select the lowest set bit, go to SETTLE.
  - start with mask 0 is ignored.
- SETTLE: lasts SYNC_STAGES+1 cycles; edges are discarded; count cleared to 0. Then go to GATE.
- GATE: exactly 2^GATE_LOG2 cycles.
  - Each detected rising edge on the selected channel adds 1.
  - The count saturates at all-ones; an edge while saturated sets the internal ovf flag.
- REPORT: 1 cycle.
  - result <= count; overflow <= ovf; result_chan <= index; done=1.
  - Next channel = next set bit above the current one in the captured mask.
  - If one exists: go to SETTLE.
  - Else if continuous=1: wrap to the lowest set bit and go to SETTLE.
  - Else: go to IDLE.
- Latency per channel: SYNC_STAGES+1 + 2^GATE_LOG2 + 1 cycles from SETTLE entry to the done pulse.
- start while busy is ignored. A chan_mask change while busy is ignored until the next start.
- continuous is sampled only in REPORT; clearing it ends the scan after the current pass.
- ena low in any state: synchronous return to IDLE next cycle; the in-flight count is discarded; result, result_chan and overflow are held; done stays 0.
- Reset mid-measurement: immediate return to reset values.
- NCH=1: result_chan is 1 bit and always 0.

Optional Feature:
Macro: RO_FREQ_METER_PEAK_EN.
- Defined:
  - Adds input peak_clr (1) and output peak (CW).
  - peak loads max(peak, new result) on each done pulse.
  - peak_clr=1 sets peak to 0; if it coincides with done, peak loads the new result.
  - peak resets to 0.
- Not defined: neither port exists and no peak logic is built.

Test Plan:
- NCH=4, CW=16, GATE_LOG2=6; mask=4'b0001; osc_in[0] period 8 clk; one start -> single done, result=8, result_chan=0, overflow=0, busy falls the cycle after done.
- Same config; mask=4'b1010; osc_in[1] period 4, osc_in[3] period 16 -> done pulses give (chan 1, 16) then (chan 3, 4); pulses are 4+64+1=69 cycles apart; then IDLE.
- CW=4, GATE_LOG2=6; osc_in[0] toggled every clk (period 2) -> result=15, overflow=1.
- continuous=1, mask=4'b0101 -> results alternate chan 0, 2, 0, 2…; drop continuous -> scan stops after the next chan 2 result.
- Mid-GATE deassert ena, or pulse reset_n -> with ena: IDLE next cycle, no done, previous result held; with reset: all outputs 0. start with mask=0 -> busy stays 0.
- With RO_FREQ_METER_PEAK_EN defined: results 8 then 4 -> peak=8; peak_clr coinciding with a done carrying 4 -> peak=4.
